phy_link_monitor: RTL and testbench
===================================

// Module: phy_link_monitor
// PURPOSE
//  Parametrised link monitor (PMA link-status process) for the 100BASE-X PHY core. Sits between the
//  PMD signal_status/descrambler lock and pcs_tx/pcs_rx. Qualifies link_status with a stabilize timer
//  and a lock-loss filter, handles loopback entry/exit, and counts link failures for management.
// PARAMETERS
//  STABILIZE_CYCLES       50000  cycles of continuous signal_status before link may come up (400 us @125 MHz)
//  TEST_STABILIZE_CYCLES  16     stabilize length when test_mode=1; >=1
//  LOCK_LOSS_CYCLES       4      consecutive !locked cycles in UP that drop the link; >=1
//  CNT_WIDTH              8      width of saturating link-fail counter
// PORTS
//  clk              in   1          PHY clock (125 MHz)
//  rst_n            in   1          synchronous reset, active low
//  signal_status    in   1          PMD signal detect
//  locked           in   1          descrambler locked
//  loopback         in   1          PCS loopback select
//  test_mode        in   1          link monitor test mode (short stabilize)
//  clr_count        in   1          synchronous clear of link_fail_count
//  desc_enable      out  1          descrambler enable (forces resync on loopback edges)
//  link_status      out  1          link OK
//  link_changed     out  1          one-cycle pulse when link_status toggles
//  link_fail_count  out  CNT_WIDTH  saturating count of UP->DOWN failures
//  state            out  2          current FSM state (debug/status)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=DOWN, timer=0, lock-loss count=0, loopback_last=0, link_status=0,
//   link_changed=0, link_fail_count=0. Reset mid-operation aborts any state; no fail count, no pulse.
//  desc_enable (comb): loopback ? loopback_last : (signal_status && !loopback_last); loopback_last<=loopback.
//  FSM (all registered; loopback=1 has priority over every other transition from any state):
//   DOWN: link_status=0. signal_status=1 -> STABILIZE, timer<=(test_mode?TEST_STABILIZE_CYCLES:STABILIZE_CYCLES)-1.
//   STABILIZE: signal_status=0 -> DOWN. timer!=0 -> timer-1. timer==0 && locked -> UP, link_status<=1;
//    timer==0 && !locked -> hold (wait for lock indefinitely while signal present).
//    test_mode sampled only at load; changing it mid-count has no effect.
//   UP: link_status=1. !locked increments lock-loss count, locked clears it. signal_status=0, or count
//    reaching LOCK_LOSS_CYCLES -> DOWN, link_status<=0, link_fail_count+1 (saturate at all-ones).
//   LOOPBACK: link_status<=locked each cycle; timer bypassed. loopback=0 -> DOWN, link_status<=0.
//    Entering LOOPBACK from UP is administrative: no fail-count increment.
//  Latency: with signal_status and locked steady high, link_status rises at the Nth edge after the edge
//   that first samples signal_status in DOWN (N = selected stabilize length).
//  link_changed <= (link_status_next != link_status); asserts the same edge link_status toggles, 1 cycle.
//  clr_count and an increment in the same cycle: clear wins (count=0).
//  Timer width = $clog2(max(STABILIZE_CYCLES,TEST_STABILIZE_CYCLES)); no wrap (stops at 0).
// STRUCTURE
//  common.vh: state encodings LM_DOWN=2'd0, LM_STABILIZE=2'd1, LM_UP=2'd2, LM_LOOPBACK=2'd3.
//  Sub-module link_timer: loadable down-counter with zero flag (load value, enable); FSM, lock-loss
//  counter, fail counter and loopback_last stay in phy_link_monitor.
// TESTING (bench params: STABILIZE=20, TEST_STABILIZE=4, LOCK_LOSS=3, CNT_WIDTH=2)
//  Bring-up: signal_status,locked=1 from edge 0 -> link_status=1 and link_changed pulse at edge 20, state UP.
//  Test mode + glitch: test_mode=1, signal_status drops at edge 2 -> DOWN, no link; re-raise -> UP 4 edges later.
//  Lock loss: in UP, locked=0 for 2 cycles -> stays UP; 3 cycles -> DOWN, fail_count=1, one link_changed.
//  Saturation/clear: 4 signal losses -> fail_count=3 (saturated); clr_count with 5th loss -> count=0.
//  Loopback: assert in UP -> LOOPBACK, desc_enable=0 for 1 cycle, link_status follows locked, count unchanged;
//   deassert -> DOWN, desc_enable low 1 cycle, re-stabilize 20 cycles.
//  Reset mid-STABILIZE (rst_n=0 one edge) -> all outputs 0, state DOWN, full re-count of 20 edges.

Source files
------------

// File: rtl/phy_link_monitor_pkg.sv
// Shared state encoding and sizing helpers for the 100BASE-X link monitor.
// No latency of its own: declarations only.
// No flow control: declarations only.
package phy_link_monitor_pkg;

    typedef enum logic [1:0] {
        LM_DOWN      = 2'd0,
        LM_STABILIZE = 2'd1,
        LM_UP        = 2'd2,
        LM_LOOPBACK  = 2'd3
    } lm_state_t;

    // Width to hold values 0..n-1. Never returns zero, so a one-value counter still gets a bit.
    function automatic int lm_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/link_timer.sv
// Loadable down-counter with a zero flag, used as the link stabilize timer.
// Latency: load/decrement take effect at the next edge; zero is combinational from the count.
// No backpressure: counting simply stops at zero.
module link_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/phy_link_monitor.sv
// PMA link-status monitor: stabilize timer, lock-loss filter, loopback handling and a fail counter.
// Latency: link_status rises N edges after signal_status is first sampled in DOWN; N is the stabilize length.
// No backpressure: all inputs are sampled every cycle.
module phy_link_monitor
    import phy_link_monitor_pkg::*;
#(
    parameter int STABILIZE_CYCLES      = 50000,
    parameter int TEST_STABILIZE_CYCLES = 16,
    parameter int LOCK_LOSS_CYCLES      = 4,
    parameter int CNT_WIDTH             = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 signal_status,
    input  logic                 locked,
    input  logic                 loopback,
    input  logic                 test_mode,
    input  logic                 clr_count,
    output logic                 desc_enable,
    output logic                 link_status,
    output logic                 link_changed,
    output logic [CNT_WIDTH-1:0] link_fail_count,
    output logic [1:0]           state
);

    localparam int TMAX = (STABILIZE_CYCLES > TEST_STABILIZE_CYCLES) ?
                          STABILIZE_CYCLES : TEST_STABILIZE_CYCLES;
    localparam int TW   = lm_width(TMAX);
    localparam int LW   = $clog2(LOCK_LOSS_CYCLES + 1);

    localparam logic [TW-1:0] LOAD_NORMAL = TW'(STABILIZE_CYCLES - 1);
    localparam logic [TW-1:0] LOAD_TEST   = TW'(TEST_STABILIZE_CYCLES - 1);

    lm_state_t     cur_state, nxt_state;
    logic [LW-1:0] ll_cnt, ll_nxt, ll_inc;
    logic          loopback_last;
    logic          ls_nxt;
    logic          fail_inc;
    logic          tmr_load, tmr_en, tmr_zero;

    link_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (test_mode ? LOAD_TEST : LOAD_NORMAL),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // Drop the descrambler enable for one cycle on each loopback edge to force a resync.
    assign desc_enable = loopback ? loopback_last : (signal_status && !loopback_last);
    assign ll_inc      = ll_cnt + LW'(1);

    always_comb begin
        nxt_state = cur_state;
        ls_nxt    = link_status;
        ll_nxt    = ll_cnt;
        fail_inc  = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        if (loopback) begin
            nxt_state = LM_LOOPBACK;
            ls_nxt    = locked;
            ll_nxt    = '0;
        end else begin
            unique case (cur_state)
                LM_DOWN: begin
                    ls_nxt = 1'b0;
                    if (signal_status) begin
                        nxt_state = LM_STABILIZE;
                        tmr_load  = 1'b1;
                    end
                end
                LM_STABILIZE: begin
                    ls_nxt = 1'b0;
                    if (!signal_status) begin
                        nxt_state = LM_DOWN;
                    end else if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else if (locked) begin
                        nxt_state = LM_UP;
                        ls_nxt    = 1'b1;
                    end
                end
                LM_UP: begin
                    ls_nxt = 1'b1;
                    ll_nxt = locked ? '0 : ll_inc;
                    if (!signal_status || (!locked && (ll_inc == LW'(LOCK_LOSS_CYCLES)))) begin
                        nxt_state = LM_DOWN;
                        ls_nxt    = 1'b0;
                        ll_nxt    = '0;
                        fail_inc  = 1'b1;
                    end
                end
                LM_LOOPBACK: begin
                    nxt_state = LM_DOWN;
                    ls_nxt    = 1'b0;
                end
                default: nxt_state = LM_DOWN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state       <= LM_DOWN;
            ll_cnt          <= '0;
            loopback_last   <= 1'b0;
            link_status     <= 1'b0;
            link_changed    <= 1'b0;
            link_fail_count <= '0;
        end else begin
            cur_state     <= nxt_state;
            ll_cnt        <= ll_nxt;
            loopback_last <= loopback;
            link_status   <= ls_nxt;
            link_changed  <= (ls_nxt != link_status);
            if (clr_count) begin
                link_fail_count <= '0;
            end else if (fail_inc && (link_fail_count != '1)) begin
                link_fail_count <= link_fail_count + CNT_WIDTH'(1);
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_phy_link_monitor.sv
// Directed bench for phy_link_monitor with short timers (stabilize 20, test 4, lock-loss 3, 2-bit count).
module tb_phy_link_monitor;

    logic       clk = 1'b0;
    logic       rst_n, signal_status, locked, loopback, test_mode, clr_count;
    logic       desc_enable, link_status, link_changed;
    logic [1:0] link_fail_count;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    localparam logic [1:0] S_DOWN = 2'd0, S_STAB = 2'd1, S_UP = 2'd2, S_LB = 2'd3;

    phy_link_monitor #(
        .STABILIZE_CYCLES(20), .TEST_STABILIZE_CYCLES(4), .LOCK_LOSS_CYCLES(3), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .signal_status(signal_status), .locked(locked),
        .loopback(loopback), .test_mode(test_mode), .clr_count(clr_count),
        .desc_enable(desc_enable), .link_status(link_status), .link_changed(link_changed),
        .link_fail_count(link_fail_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; signal_status = 1'b0; locked = 1'b0; loopback = 1'b0;
        test_mode = 1'b0; clr_count = 1'b0;
        tick(); tick();
        tests++; if (state !== S_DOWN) begin fails++; $display("FAIL reset_state got %0d want %0d", state, S_DOWN); end
        tests++; if (link_status !== 1'b0) begin fails++; $display("FAIL reset_link got %0b want 0", link_status); end
        tests++; if (link_changed !== 1'b0) begin fails++; $display("FAIL reset_changed got %0b want 0", link_changed); end
        tests++; if (link_fail_count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", link_fail_count); end
        tests++; if (desc_enable !== 1'b0) begin fails++; $display("FAIL reset_desc got %0b want 0", desc_enable); end
        rst_n = 1'b1;
        tick();
    endtask

    // Holds signal and lock high from edge 0 and checks link comes up exactly at edge n.
    task automatic test_bringup(input int n, input string tag);
        signal_status = 1'b1; locked = 1'b1;
        for (int e = 0; e <= n; e++) begin
            tick();
            if (e == 0) begin
                tests++; if (state !== S_STAB) begin fails++; $display("FAIL %s_stab got %0d want %0d", tag, state, S_STAB); end
            end
            if (e < n) begin
                tests++; if (link_status !== 1'b0) begin fails++; $display("FAIL %s_early edge %0d got %0b want 0", tag, e, link_status); end
            end else begin
                tests++; if (link_status !== 1'b1) begin fails++; $display("FAIL %s_up got %0b want 1", tag, link_status); end
                tests++; if (link_changed !== 1'b1) begin fails++; $display("FAIL %s_pulse got %0b want 1", tag, link_changed); end
                tests++; if (state !== S_UP) begin fails++; $display("FAIL %s_state got %0d want %0d", tag, state, S_UP); end
            end
        end
        tick();
        tests++; if (link_changed !== 1'b0) begin fails++; $display("FAIL %s_pulse_len got %0b want 0", tag, link_changed); end
    endtask

    task automatic test_lock_loss();
        locked = 1'b0; tick(); tick();
        tests++; if (state !== S_UP) begin fails++; $display("FAIL ll2_state got %0d want %0d", state, S_UP); end
        locked = 1'b1; tick();
        locked = 1'b0; tick(); tick();
        tests++; if (link_status !== 1'b1) begin fails++; $display("FAIL ll_cleared got %0b want 1", link_status); end
        tick();
        exp_cnt = 1;
        tests++; if (state !== S_DOWN) begin fails++; $display("FAIL ll3_state got %0d want %0d", state, S_DOWN); end
        tests++; if (link_status !== 1'b0) begin fails++; $display("FAIL ll3_link got %0b want 0", link_status); end
        tests++; if (link_changed !== 1'b1) begin fails++; $display("FAIL ll3_pulse got %0b want 1", link_changed); end
        tests++; if (link_fail_count !== 2'(exp_cnt)) begin fails++; $display("FAIL ll3_count got %0d want %0d", link_fail_count, exp_cnt); end
        locked = 1'b1; tick();
        tests++; if (link_changed !== 1'b0) begin fails++; $display("FAIL ll3_pulse_len got %0b want 0", link_changed); end
    endtask

    task automatic test_mode_glitch();
        signal_status = 1'b0; tick(); tick();
        test_mode = 1'b1; signal_status = 1'b1; locked = 1'b1;
        tick(); tick();
        signal_status = 1'b0; tick();
        tests++; if (state !== S_DOWN) begin fails++; $display("FAIL glitch_state got %0d want %0d", state, S_DOWN); end
        tests++; if (link_status !== 1'b0) begin fails++; $display("FAIL glitch_link got %0b want 0", link_status); end
        // Re-raise; test_mode flips mid-count and must not stretch the 4-edge stabilize.
        signal_status = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            tick();
            if (e == 1) test_mode = 1'b0;
            tests++;
            if (link_status !== (e == 4)) begin fails++; $display("FAIL tm_up edge %0d got %0b want %0b", e, link_status, (e == 4)); end
        end
        tests++; if (link_fail_count !== 2'(exp_cnt)) begin fails++; $display("FAIL glitch_count got %0d want %0d", link_fail_count, exp_cnt); end
    endtask

    task automatic test_saturation();
        test_mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) clr_count = 1'b1;
            signal_status = 1'b0; tick();
            clr_count = 1'b0;
            exp_cnt = (k == 4) ? 0 : ((exp_cnt < 3) ? exp_cnt + 1 : 3);
            tests++; if (link_fail_count !== 2'(exp_cnt)) begin fails++; $display("FAIL sat_count loss %0d got %0d want %0d", k, link_fail_count, exp_cnt); end
            signal_status = 1'b1;
            for (int e = 0; e < 5; e++) tick();
            tests++; if (state !== S_UP) begin fails++; $display("FAIL sat_relink loss %0d got %0d want %0d", k, state, S_UP); end
        end
        test_mode = 1'b0;
    endtask

    task automatic test_loopback();
        loopback = 1'b1; #1;
        tests++; if (desc_enable !== 1'b0) begin fails++; $display("FAIL lb_desc_enter got %0b want 0", desc_enable); end
        tick();
        tests++; if (state !== S_LB) begin fails++; $display("FAIL lb_state got %0d want %0d", state, S_LB); end
        tests++; if (desc_enable !== 1'b1) begin fails++; $display("FAIL lb_desc_after got %0b want 1", desc_enable); end
        tests++; if (link_status !== 1'b1) begin fails++; $display("FAIL lb_link got %0b want 1", link_status); end
        locked = 1'b0; tick();
        tests++; if (link_status !== 1'b0) begin fails++; $display("FAIL lb_follow0 got %0b want 0", link_status); end
        locked = 1'b1; tick();
        tests++; if (link_status !== 1'b1) begin fails++; $display("FAIL lb_follow1 got %0b want 1", link_status); end
        tests++; if (link_fail_count !== 2'(exp_cnt)) begin fails++; $display("FAIL lb_count got %0d want %0d", link_fail_count, exp_cnt); end
        loopback = 1'b0; #1;
        tests++; if (desc_enable !== 1'b0) begin fails++; $display("FAIL lb_desc_exit got %0b want 0", desc_enable); end
        tick();
        tests++; if (state !== S_DOWN) begin fails++; $display("FAIL lb_exit_state got %0d want %0d", state, S_DOWN); end
        tests++; if (link_changed !== 1'b1) begin fails++; $display("FAIL lb_exit_pulse got %0b want 1", link_changed); end
        tests++; if (desc_enable !== 1'b1) begin fails++; $display("FAIL lb_desc_restore got %0b want 1", desc_enable); end
        test_bringup(20, "lb_restab");
        tests++; if (link_fail_count !== 2'(exp_cnt)) begin fails++; $display("FAIL lb_count_end got %0d want %0d", link_fail_count, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        signal_status = 1'b0; tick();
        signal_status = 1'b1;
        for (int e = 0; e < 6; e++) tick();
        tests++; if (state !== S_STAB) begin fails++; $display("FAIL rm_pre_state got %0d want %0d", state, S_STAB); end
        rst_n = 1'b0; tick();
        tests++; if (state !== S_DOWN) begin fails++; $display("FAIL rm_state got %0d want %0d", state, S_DOWN); end
        tests++; if (link_status !== 1'b0) begin fails++; $display("FAIL rm_link got %0b want 0", link_status); end
        tests++; if (link_changed !== 1'b0) begin fails++; $display("FAIL rm_pulse got %0b want 0", link_changed); end
        tests++; if (link_fail_count !== 2'd0) begin fails++; $display("FAIL rm_count got %0d want 0", link_fail_count); end
        rst_n = 1'b1;
        test_bringup(20, "rm_restab");
    endtask

    initial begin
        test_reset();
        test_bringup(20, "bringup");
        test_lock_loss();
        test_mode_glitch();
        test_saturation();
        test_loopback();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
